// File: rtl/elevator_pkg.sv
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared types and defaults for the elevator request scheduler:
//                FSM state encoding, direction constants, floor-count defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  // Travel direction encoding carried on down_up_flag
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Default building geometry
  localparam int DEF_NUM_FLOORS = 4;
  localparam int DEF_FLOOR_W    = 2;

endpackage

`default_nettype wire

// File: rtl/elevator_door_timer.sv
// ============================================================================
//  Module      : elevator_door_timer
//  Description : Door dwell counter. load (re)starts the count at DOOR_CYCLES,
//                dec counts down toward zero, done flags the final open cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_door_timer #(
  parameter int DOOR_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CNT_W = $clog2(DOOR_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Load has priority so a same-floor request during dwell restarts the full time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(DOOR_CYCLES);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // The cycle the count reads 1 is the last cycle the door is held open
  assign done = (count == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/elevator_request_scheduler.sv
// ============================================================================
//  Module      : elevator_request_scheduler
//  Description : SCAN elevator scheduler. Latches floor requests into a
//                pending bitmask, sequences motor/door, tracks the car floor
//                from shaft-sensor pulses and reports the next target floor.
//                Optional stop counter enabled by macro ELEV_TRIP_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int FLOOR_W     = DEF_FLOOR_W,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [2:0]            req_floor,
  output logic                  req_err,
  input  logic                  floor_arrive,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    actual_floor,
  output logic                  down_up_flag,
  output logic [2:0]            next_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy,
  output logic [15:0]           trip_count
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  state_t                  state;
  state_t                  state_nx;
  state_t                  dec_state;
  logic                    dec_up;
  logic                    dir_nx;
  logic [FLOOR_W-1:0]      floor_nx;
  logic [NUM_FLOORS-1:0]   set_mask;
  logic [NUM_FLOORS-1:0]   clr_mask;
  logic                    above;
  logic                    below;
  logic                    req_ok;
  logic [FLOOR_W-1:0]      req_idx;
  logic                    req_here;
  logic                    timer_load;
  logic                    timer_done;

  assign req_ok   = req_valid && (int'(req_floor) < NUM_FLOORS);
  assign req_idx  = req_floor[FLOOR_W-1:0];
  assign req_here = req_ok && (req_idx == actual_floor);

  elevator_door_timer #(
    .DOOR_CYCLES (DOOR_CYCLES)
  ) u_door_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .dec   (state == DOOR),
    .done  (timer_done)
  );

  // Are there pending requests strictly above / below the car?
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i > int'(actual_floor))) above = 1'b1;
      if (pending[i] && (i < int'(actual_floor))) below = 1'b1;
    end
  end

  // Nearest pending floor in the travel direction, else the current floor
  always_comb begin
    next_floor = 3'(actual_floor);
    if (down_up_flag == DIR_UP) begin
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
        if (pending[i] && (i > int'(actual_floor))) next_floor = 3'(i);
      end
    end else begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (pending[i] && (i < int'(actual_floor))) next_floor = 3'(i);
      end
    end
  end

  // SCAN decision: keep the current direction while it still has work
  always_comb begin
    dec_state = IDLE;
    dec_up    = down_up_flag;
    if ((down_up_flag == DIR_UP) && above) begin
      dec_state = MOVE_UP;
    end else if (below) begin
      dec_state = MOVE_DOWN;
      dec_up    = DIR_DOWN;
    end else if (above) begin
      dec_state = MOVE_UP;
      dec_up    = DIR_UP;
    end
  end

  // Next-state, floor tracking and pending-mask updates
  always_comb begin
    state_nx   = state;
    dir_nx     = down_up_flag;
    floor_nx   = actual_floor;
    timer_load = 1'b0;
    set_mask   = '0;
    clr_mask   = '0;

    // A request for the floor the car is parked at opens/holds the door instead
    if (req_ok && !(req_here && ((state == IDLE) || (state == DOOR)))) begin
      set_mask[req_idx] = 1'b1;
    end

    case (state)
      IDLE: begin
        if (req_here) begin
          state_nx   = DOOR;
          timer_load = 1'b1;
        end else begin
          state_nx = dec_state;
          dir_nx   = dec_up;
        end
      end
      DOOR: begin
        if (req_here) begin
          timer_load = 1'b1;
        end else if (timer_done) begin
          state_nx = dec_state;
          dir_nx   = dec_up;
        end
      end
      MOVE_UP: begin
        if (floor_arrive) begin
          if (actual_floor != TOP_FLOOR) floor_nx = actual_floor + FLOOR_W'(1);
          // Stop on a pending floor, a request landing this very cycle, or the top end
          if ((actual_floor == TOP_FLOOR) || pending[floor_nx] ||
              (req_ok && (req_idx == floor_nx))) begin
            state_nx           = DOOR;
            timer_load         = 1'b1;
            clr_mask[floor_nx] = 1'b1;
          end
        end
      end
      MOVE_DOWN: begin
        if (floor_arrive) begin
          if (actual_floor != '0) floor_nx = actual_floor - FLOOR_W'(1);
          if ((actual_floor == '0) || pending[floor_nx] ||
              (req_ok && (req_idx == floor_nx))) begin
            state_nx           = DOOR;
            timer_load         = 1'b1;
            clr_mask[floor_nx] = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register with Moore outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pending      <= '0;
      actual_floor <= '0;
      down_up_flag <= DIR_UP;
      motor_up     <= 1'b0;
      motor_down   <= 1'b0;
      door_open    <= 1'b0;
      busy         <= 1'b0;
      req_err      <= 1'b0;
    end else begin
      state        <= state_nx;
      // Clearing wins, so a request merged with its own stop leaves the bit clear
      pending      <= (pending | set_mask) & ~clr_mask;
      actual_floor <= floor_nx;
      down_up_flag <= dir_nx;
      motor_up     <= (state_nx == MOVE_UP);
      motor_down   <= (state_nx == MOVE_DOWN);
      door_open    <= (state_nx == DOOR);
      busy         <= (state_nx != IDLE);
      req_err      <= req_valid && !req_ok;
    end
  end

`ifdef ELEV_TRIP_COUNT_EN
  // Count every fresh entry into DOOR, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trip_count <= '0;
    end else if ((state_nx == DOOR) && (state != DOOR) && (trip_count != 16'hFFFF)) begin
      trip_count <= trip_count + 16'd1;
    end
  end
`else
  assign trip_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_elevator_request_scheduler.sv
// ============================================================================
//  Module      : tb_elevator_request_scheduler
//  Description : Self-checking bench for elevator_request_scheduler
//                (4 floors, 8-cycle door dwell).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elevator_request_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_floor = 3'd0;
  logic       floor_arrive = 1'b0;
  logic       req_err;
  logic       motor_up;
  logic       motor_down;
  logic       door_open;
  logic [1:0] actual_floor;
  logic       down_up_flag;
  logic [2:0] next_floor;
  logic [3:0] pending;
  logic       busy;
  logic [15:0] trip_count;

  int n_checks = 0;
  int n_fail   = 0;

  // {mu, md, door, floor[1:0], flag, next[2:0], pending[3:0], busy, err}
  typedef struct packed {
    logic        rv;
    logic [2:0]  rf;
    logic        fa;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs [29];

  elevator_request_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .req_err      (req_err),
    .floor_arrive (floor_arrive),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .door_open    (door_open),
    .actual_floor (actual_floor),
    .down_up_flag (down_up_flag),
    .next_floor   (next_floor),
    .pending      (pending),
    .busy         (busy),
    .trip_count   (trip_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rv, input logic [2:0] rf, input logic fa,
                              input logic mu, input logic md, input logic dop,
                              input logic [1:0] af, input logic fl, input logic [2:0] nf,
                              input logic [3:0] pd, input logic bz, input logic er);
    vec_t v;
    v.rv  = rv;
    v.rf  = rf;
    v.fa  = fa;
    v.exp = {mu, md, dop, af, fl, nf, pd, bz, er};
    return v;
  endfunction

  function automatic logic [14:0] outs();
    return {motor_up, motor_down, door_open, actual_floor, down_up_flag,
            next_floor, pending, busy, req_err};
  endfunction

  // Drive one cycle of inputs, then sample 1 ns after the edge
  task automatic step(input logic rv, input logic [2:0] rf, input logic fa);
    req_valid    = rv;
    req_floor    = rf;
    floor_arrive = fa;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_floor    = 3'd0;
    floor_arrive = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Idle until the door shuts; an overlong dwell counts as a failure
  task automatic wait_door_close(input string name);
    int n;
    n = 0;
    while (door_open && n < 40) begin
      step(1'b0, 3'd0, 1'b0);
      n++;
    end
    check(name, {31'd0, door_open}, 32'd0);
  endtask

  initial begin
    int k;
    int n;

    // ---------------- vector table: request to floor 2, return to 0 -------
    k = 0;
    vecs[k++] = mk(0,3'd0,0, 0,0,0, 2'd0,1,3'd0, 4'b0000, 0,0);
    vecs[k++] = mk(1,3'd2,0, 0,0,0, 2'd0,1,3'd2, 4'b0100, 0,0);
    vecs[k++] = mk(0,3'd0,0, 1,0,0, 2'd0,1,3'd2, 4'b0100, 1,0);
    vecs[k++] = mk(0,3'd0,1, 1,0,0, 2'd1,1,3'd2, 4'b0100, 1,0);
    vecs[k++] = mk(0,3'd0,0, 1,0,0, 2'd1,1,3'd2, 4'b0100, 1,0);
    vecs[k++] = mk(0,3'd0,1, 0,0,1, 2'd2,1,3'd2, 4'b0000, 1,0);
    for (int i = 0; i < 7; i++)
      vecs[k++] = mk(0,3'd0,0, 0,0,1, 2'd2,1,3'd2, 4'b0000, 1,0);
    vecs[k++] = mk(0,3'd0,0, 0,0,0, 2'd2,1,3'd2, 4'b0000, 0,0);
    vecs[k++] = mk(1,3'd5,0, 0,0,0, 2'd2,1,3'd2, 4'b0000, 0,1);
    vecs[k++] = mk(0,3'd0,0, 0,0,0, 2'd2,1,3'd2, 4'b0000, 0,0);
    vecs[k++] = mk(1,3'd0,0, 0,0,0, 2'd2,1,3'd2, 4'b0001, 0,0);
    vecs[k++] = mk(0,3'd0,0, 0,1,0, 2'd2,0,3'd0, 4'b0001, 1,0);
    vecs[k++] = mk(1,3'd5,1, 0,1,0, 2'd1,0,3'd0, 4'b0001, 1,1);
    vecs[k++] = mk(0,3'd0,0, 0,1,0, 2'd1,0,3'd0, 4'b0001, 1,0);
    vecs[k++] = mk(0,3'd0,1, 0,0,1, 2'd0,0,3'd0, 4'b0000, 1,0);
    for (int i = 0; i < 7; i++)
      vecs[k++] = mk(0,3'd0,0, 0,0,1, 2'd0,0,3'd0, 4'b0000, 1,0);
    vecs[k++] = mk(0,3'd0,0, 0,0,0, 2'd0,0,3'd0, 4'b0000, 0,0);

    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      step(vecs[i].rv, vecs[i].rf, vecs[i].fa);
      n_checks++;
      if (outs() !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d: got %b expected %b", i, outs(), vecs[i].exp);
      end
    end

    // ---------------- reverse at the top: pending {3,0} from floor 1 -------
    step(1'b1, 3'd3, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    check("scan_start_up", {30'd0, motor_up, down_up_flag}, 32'h3);
    step(1'b0, 3'd0, 1'b1);
    step(1'b1, 3'd0, 1'b0);
    check("pend_3_0", {28'd0, pending}, 32'h9);
    check("next_up_from1", {29'd0, next_floor}, 32'd3);
    step(1'b0, 3'd0, 1'b1);
    step(1'b0, 3'd0, 1'b1);
    check("stop_at3", {25'd0, door_open, actual_floor, pending}, {25'd0, 1'b1, 2'd3, 4'b0001});
    repeat (7) step(1'b0, 3'd0, 1'b0);
    check("door3_still_open", {31'd0, door_open}, 32'd1);
    step(1'b0, 3'd0, 1'b0);
    check("reverse_down", {26'd0, motor_down, down_up_flag, next_floor, door_open},
          {26'd0, 1'b1, 1'b0, 3'd0, 1'b0});

    // ---------------- door reload at floor 1 --------------------------------
    step(1'b1, 3'd1, 1'b0);
    step(1'b0, 3'd0, 1'b1);
    step(1'b0, 3'd0, 1'b1);
    check("stop_at1", {25'd0, door_open, actual_floor, pending}, {25'd0, 1'b1, 2'd1, 4'b0001});
    repeat (4) step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    check("reload_pend", {27'd0, door_open, pending}, {27'd0, 1'b1, 4'b0001});
    n = 1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 3'd0, 1'b0);
      if (door_open) n++;
      else break;
    end
    check("reload_dwell", n, 32'd8);
    check("after_reload_down", {31'd0, motor_down}, 32'd1);

    // ---------------- request merged with arrival at floor 2 ----------------
    step(1'b0, 3'd0, 1'b1);
    check("stop_at0", {29'd0, door_open, actual_floor}, {29'd0, 1'b1, 2'd0});
    wait_door_close("door0_close");
    check("idle_at0", {31'd0, busy}, 32'd0);
    step(1'b1, 3'd3, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b1);
    step(1'b1, 3'd2, 1'b1);
    check("merge_stop2", {25'd0, door_open, actual_floor, pending}, {25'd0, 1'b1, 2'd2, 4'b1000});
    wait_door_close("door2_close");
    check("continue_up", {30'd0, motor_up, down_up_flag}, 32'h3);
    step(1'b0, 3'd0, 1'b1);
    check("stop_at3_again", {25'd0, door_open, actual_floor, pending}, {25'd0, 1'b1, 2'd3, 4'b0000});
    step(1'b0, 3'd0, 1'b1);
    check("arrive_ignored_door", {30'd0, actual_floor}, 32'd3);
`ifdef ELEV_TRIP_COUNT_EN
    check("trip_count", {16'd0, trip_count}, 32'd7);
`else
    check("trip_count", {16'd0, trip_count}, 32'd0);
`endif
    wait_door_close("door3_close");
    check("idle_at3", {31'd0, busy}, 32'd0);
    step(1'b1, 3'd3, 1'b0);
    check("same_floor_idle", {27'd0, door_open, pending}, {27'd0, 1'b1, 4'b0000});
    wait_door_close("door3b_close");

    // ---------------- asynchronous reset mid MOVE_DOWN ----------------------
    step(1'b1, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b1);
    check("pre_reset_move", {29'd0, motor_down, actual_floor}, {29'd0, 1'b1, 2'd2});
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {17'd0, outs()}, {17'd0, 15'b000_00_1_000_0000_0_0});
    check("async_reset_trip", {16'd0, trip_count}, 32'd0);
    rst_n = 1'b1;
    step(1'b0, 3'd0, 1'b0);
    check("post_reset_idle", {17'd0, outs()}, {17'd0, 15'b000_00_1_000_0000_0_0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
